// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode and control-encoding definitions shared by the multicycle controller.
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, ADDI_WB, EXECUTE, R_WB, BRANCH, JUMP, TRAP
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUSRCB_RT      = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM     = 2'd2;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       trap;
  } ctrl_t;
  function automatic logic is_mem_state(input state_e s);
    return s inside {FETCH, MEM_READ, MEM_WRITE};
  endfunction
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational map from controller state to the datapath control bundle.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   is_zero_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.alu_src_b = ALUSRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      DECODE: ctrl_o.alu_src_b = ALUSRCB_IMM_SH2;
      MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_IMM;
      end
      MEM_READ: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.i_or_d  = 1'b1;
      end
      MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.i_or_d  = 1'b1;
      end
      ADDI_WB: ctrl_o.reg_write = 1'b1;
      EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_RT;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ALUSRCB_RT;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_source = PCSRC_ALUOUT;
        ctrl_o.pc_write  = is_zero_i;
      end
      JUMP: begin
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.pc_write  = 1'b1;
      end
      TRAP: ctrl_o.trap = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS sequencer with memory handshake and timeout trap.
// Defining MIPS_CTRL_PERF_EN adds cycle_cnt_o/instr_cnt_o performance counters.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int PERF_W      = 32
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       is_zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_source_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       trap_o
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt_o,
  output logic [PERF_W-1:0] instr_cnt_o
`endif
);
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout;
  ctrl_t         ctrl_raw, ctrl;
  logic          unused_funct;
  // funct is decoded by the ALU control, not here
  assign unused_funct = ^funct_i;
  assign timeout = (MEM_TIMEOUT != 0) && (32'(cnt_q) == MEM_TIMEOUT - 1) && is_mem_state(state_q);
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     state_d = mem_ready_i ? DECODE : (timeout ? TRAP : FETCH);
      DECODE:    state_d = opcode_i == OP_RTYPE ? EXECUTE :
                           opcode_i inside {OP_LW, OP_SW, OP_ADDI} ? MEM_ADDR :
                           opcode_i == OP_BEQ ? BRANCH :
                           opcode_i == OP_J ? JUMP : TRAP;
      MEM_ADDR:  state_d = opcode_i == OP_LW ? MEM_READ : (opcode_i == OP_SW ? MEM_WRITE : ADDI_WB);
      MEM_READ:  state_d = mem_ready_i ? MEM_WB : (timeout ? TRAP : MEM_READ);
      MEM_WRITE: state_d = mem_ready_i ? FETCH : (timeout ? TRAP : MEM_WRITE);
      EXECUTE:   state_d = R_WB;
      TRAP:      state_d = TRAP;
      default:   state_d = FETCH;
    endcase
  end
  // wait counter restarts whenever the state changes, so each memory access gets a fresh budget
  assign cnt_d = (state_d == state_q) ? cnt_q + 1'b1 : '0;
`ifdef MIPS_CTRL_PERF_EN
  logic [PERF_W-1:0] cycle_cnt_q, instr_cnt_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;
`else
  localparam int unused_perf_w = PERF_W;
`endif
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= FETCH;
      cnt_q   <= '0;
`ifdef MIPS_CTRL_PERF_EN
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef MIPS_CTRL_PERF_EN
      if (state_q != TRAP) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (state_d == FETCH && state_q != FETCH) instr_cnt_q <= instr_cnt_q + 1'b1;
`endif
    end
  end
  mips_ctrl_decode u_decode (
    .state_i    (state_q),
    .is_zero_i  (is_zero_i),
    .mem_ready_i(mem_ready_i),
    .ctrl_o     (ctrl_raw)
  );
  // reset aborts any access combinationally in the reset cycle itself
  assign ctrl         = reset_i ? '0 : ctrl_raw;
  assign mem_req_o    = ctrl.mem_req;
  assign mem_we_o     = ctrl.mem_we;
  assign i_or_d_o     = ctrl.i_or_d;
  assign ir_write_o   = ctrl.ir_write;
  assign pc_write_o   = ctrl.pc_write;
  assign pc_source_o  = ctrl.pc_source;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign reg_write_o  = ctrl.reg_write;
  assign trap_o       = ctrl.trap;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed per-cycle checks of the multicycle controller outputs.
module tb_mips_multicycle_control;
  typedef enum {P_RST, P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_AWB, P_EX, P_RWB, P_BR, P_J, P_TRAP} ph_e;
  typedef struct {
    string       tag;
    logic [15:0] exp;
  } item_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       is_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, alu_src_a, reg_dst, mem_to_reg, reg_write, trap;
  logic [1:0] pc_source, alu_src_b, alu_op;
  int         tests = 0;
  int         fails = 0;
  item_t      sb[$];
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif
  always #5 clk = ~clk;
  mips_multicycle_control #(.MEM_TIMEOUT(4), .PERF_W(32)) dut (
    .clock_i(clk), .reset_i(rst), .opcode_i(opcode), .funct_i(funct), .is_zero_i(is_zero),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we), .i_or_d_o(i_or_d),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_source_o(pc_source), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .reg_write_o(reg_write), .trap_o(trap)
`ifdef MIPS_CTRL_PERF_EN
    , .cycle_cnt_o(cycle_cnt), .instr_cnt_o(instr_cnt)
`endif
  );
  // expected control vector per phase, straight from the state/output table
  function automatic logic [15:0] model(input ph_e p, input bit rdy, input bit iz);
    logic mr = 0, we = 0, iod = 0, irw = 0, pcw = 0, a = 0, rd = 0, m2r = 0, rw = 0, tr = 0;
    logic [1:0] ps = 0, b = 0, op = 0;
    case (p)
      P_F:    begin mr = 1; irw = rdy; pcw = rdy; b = 2'd1; end
      P_D:    b = 2'd3;
      P_MA:   begin a = 1; b = 2'd2; end
      P_MR:   begin mr = 1; iod = 1; end
      P_MWB:  begin rw = 1; m2r = 1; end
      P_MW:   begin mr = 1; we = 1; iod = 1; end
      P_AWB:  rw = 1;
      P_EX:   begin a = 1; op = 2'b10; end
      P_RWB:  begin rw = 1; rd = 1; end
      P_BR:   begin a = 1; op = 2'b01; ps = 2'd1; pcw = iz; end
      P_J:    begin ps = 2'd2; pcw = 1; end
      P_TRAP: tr = 1;
      default: ;
    endcase
    return {mr, we, iod, irw, pcw, ps, a, b, op, rd, m2r, rw, tr};
  endfunction
  task automatic check_one();
    item_t it;
    logic [15:0] obs;
    it = sb.pop_front();
    obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source, alu_src_a, alu_src_b, alu_op,
           reg_dst, mem_to_reg, reg_write, trap};
    tests++;
    assert (obs === it.exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
    end
  endtask
  task automatic step(input ph_e p, input string tag, input logic [5:0] op, input bit rdy, input bit iz,
                      input bit r);
    @(negedge clk);
    opcode = op;
    mem_ready = rdy;
    is_zero = iz;
    rst = r;
    sb.push_back('{tag, model(p, rdy, iz)});
    #1;
    check_one();
  endtask
  initial begin
    step(P_RST, "reset0", 6'h00, 1, 1, 1);
    step(P_RST, "reset1", 6'h23, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(P_F, "j_fetch", 6'h02, 1, 0, 0);
      step(P_D, "j_decode", 6'h02, 0, 0, 0);
      step(P_J, "j_jump", 6'h02, 0, 0, 0);
    end
    step(P_F, "r_fetch", 6'h00, 1, 0, 0);
`ifdef MIPS_CTRL_PERF_EN
    tests++;
    assert (cycle_cnt === 32'd9) else begin
      fails++;
      $error("FAIL cycle_cnt observed=%0d expected=9", cycle_cnt);
    end
    tests++;
    assert (instr_cnt === 32'd3) else begin
      fails++;
      $error("FAIL instr_cnt observed=%0d expected=3", instr_cnt);
    end
`endif
    step(P_D, "r_decode", 6'h00, 0, 0, 0);
    step(P_EX, "r_exec", 6'h00, 0, 1, 0);
    step(P_RWB, "r_wb", 6'h00, 1, 0, 0);
    step(P_F, "lw_fetch", 6'h23, 1, 0, 0);
    step(P_D, "lw_decode", 6'h23, 1, 0, 0);
    step(P_MA, "lw_addr", 6'h23, 0, 0, 0);
    step(P_MR, "lw_wait1", 6'h23, 0, 0, 0);
    step(P_MR, "lw_wait2", 6'h23, 0, 0, 0);
    step(P_MR, "lw_ready", 6'h23, 1, 0, 0);
    step(P_MWB, "lw_wb", 6'h23, 0, 0, 0);
    step(P_F, "beq1_fetch", 6'h04, 1, 1, 0);
    step(P_D, "beq1_decode", 6'h04, 0, 1, 0);
    step(P_BR, "beq_taken", 6'h04, 0, 1, 0);
    step(P_F, "beq0_fetch", 6'h04, 1, 0, 0);
    step(P_D, "beq0_decode", 6'h04, 0, 0, 0);
    step(P_BR, "beq_not_taken", 6'h04, 1, 0, 0);
    step(P_F, "sw_fetch", 6'h2B, 1, 0, 0);
    step(P_D, "sw_decode", 6'h2B, 0, 0, 0);
    step(P_MA, "sw_addr", 6'h2B, 0, 0, 0);
    step(P_MW, "sw_write", 6'h2B, 1, 0, 0);
    step(P_F, "addi_fetch", 6'h08, 1, 0, 0);
    step(P_D, "addi_decode", 6'h08, 0, 0, 0);
    step(P_MA, "addi_addr", 6'h08, 1, 0, 0);
    step(P_AWB, "addi_wb", 6'h08, 0, 0, 0);
    step(P_F, "swr_fetch", 6'h2B, 1, 0, 0);
    step(P_D, "swr_decode", 6'h2B, 0, 0, 0);
    step(P_MA, "swr_addr", 6'h2B, 0, 0, 0);
    step(P_MW, "swr_wait", 6'h2B, 0, 0, 0);
    step(P_RST, "swr_reset", 6'h2B, 0, 0, 1);
    step(P_F, "swr_restart", 6'h3F, 1, 0, 0);
    step(P_D, "ill_decode", 6'h3F, 0, 0, 0);
    step(P_TRAP, "ill_trap", 6'h3F, 1, 1, 0);
    step(P_TRAP, "ill_trap_hold", 6'h00, 1, 1, 0);
    step(P_RST, "ill_reset", 6'h00, 0, 0, 1);
    step(P_F, "to_wait1", 6'h00, 0, 0, 0);
    step(P_F, "to_wait2", 6'h00, 0, 0, 0);
    step(P_F, "to_wait3", 6'h00, 0, 0, 0);
    step(P_F, "to_wait4", 6'h00, 0, 0, 0);
    step(P_TRAP, "to_trap", 6'h00, 0, 0, 0);
    step(P_TRAP, "to_trap_hold", 6'h00, 1, 0, 0);
    step(P_RST, "to_reset", 6'h00, 0, 0, 1);
    step(P_F, "post_fetch", 6'h00, 1, 0, 0);
    step(P_D, "post_decode", 6'h00, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
